pipe_mem_access: RTL and testbench

PIPE_MEM_ACCESS -- requirements
Module: pipe_mem_access

---
 rtl/pipe_mem_access.sv | 184 ++++++++++++++++++
 tb/tb_pipe_mem_access.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_access.sv
// rtl/pipe_mem_access.sv - M-stage data-memory access with bus handshake and MEM/WB register
//
// Purpose:
//   Turns the M-stage control/data from the EX/MEM register into a single
//   request/acknowledge data-bus transaction, stalls the earlier pipeline
//   stages while the bus is busy, and owns the MEM/WB pipeline register.
//   A memory op takes the IDLE cycle (latch the bus fields) plus at least one
//   REQ cycle. A non-memory op passes straight through in one cycle.
//
// Configuration:
//   PIPE_MEM_TIMEOUT_EN - when defined, a REQ that sees no mem_ack for
//                         ACK_TIMEOUT cycles is dropped. It writes a bubble
//                         into MEM/WB and pulses mem_err for one cycle.
//                         When undefined, REQ waits forever and mem_err is 0.
//
// Ports:
//   clock                  rising-edge clock
//   resetn                 synchronous active-low reset
//   mwreg, mm2reg, mwmem   M-stage control (register write, load, store)
//   malu, mb               M-stage address/ALU result and store data
//   mrn                    M-stage destination register
//   mstall                 combinational hold request to EX/MEM and earlier
//   mem_req, mem_we        data-bus request and write enable
//   mem_addr, mem_wdata    data-bus address and write data
//   mem_ack, mem_rdata     data-bus completion and read data
//   wwreg, wm2reg          MEM/WB control
//   wmo, walu              MEM/WB load data and ALU result
//   wrn                    MEM/WB destination register
//   mem_err                one-cycle bus-timeout pulse

module pipe_mem_access #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        mstall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state;
    logic   memop;
    logic   timeout;

    // A store wins when both load and store are flagged.
    assign memop = mm2reg | mwmem;

`ifdef PIPE_MEM_TIMEOUT_EN
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CW-1:0] req_cnt;

    // req_cnt holds the 0-based index of the current REQ cycle, so the
    // last allowed REQ cycle is ACK_TIMEOUT-1. An ack on that cycle still wins.
    assign timeout = (state == REQ) && !mem_ack &&
                     (req_cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!resetn || state != REQ) begin
            req_cnt <= '0;
        end else begin
            req_cnt <= req_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    // The stall drops in the final REQ cycle (ack or timeout). The
    // instruction held in M then retires on the same edge as the FSM
    // returns to IDLE.
    always_comb begin
        mstall = 1'b0;
        case (state)
            IDLE:    mstall = memop;
            REQ:     mstall = !mem_ack && !timeout;
            default: mstall = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            wmo       <= '0;
            walu      <= '0;
            wrn       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        // Latch the bus fields once. They stay frozen for
                        // the whole REQ phase even though M keeps driving
                        // them, because the stall holds EX/MEM.
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= mwmem;
                        mem_addr  <= malu;
                        mem_wdata <= mb;
                        wwreg     <= 1'b0;
                        wm2reg    <= 1'b0;
                        wmo       <= '0;
                        walu      <= '0;
                        wrn       <= '0;
                    end else begin
                        wwreg     <= mwreg;
                        wm2reg    <= 1'b0;
                        wmo       <= '0;
                        walu      <= malu;
                        wrn       <= mrn;
                    end
                end

                REQ: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        wwreg     <= mwreg;
                        wm2reg    <= mm2reg & ~mwmem;
                        wmo       <= (mm2reg & ~mwmem) ? mem_rdata : 32'h0;
                        walu      <= malu;
                        wrn       <= mrn;
                    end else begin
                        // Still waiting, or giving up on timeout. In both
                        // cases nothing may be written back this cycle.
                        if (timeout) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                        wwreg     <= 1'b0;
                        wm2reg    <= 1'b0;
                        wmo       <= '0;
                        walu      <= '0;
                        wrn       <= '0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mem_access.sv
// tb/tb_pipe_mem_access.sv - scoreboard bench for pipe_mem_access

module tb_pipe_mem_access;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        mstall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;
    logic        mem_err;

    always #5 clock = ~clock;

    pipe_mem_access #(.ACK_TIMEOUT(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .mrn       (mrn),
        .mstall    (mstall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wwreg     (wwreg),
        .wm2reg    (wm2reg),
        .wmo       (wmo),
        .walu      (walu),
        .wrn       (wrn),
        .mem_err   (mem_err)
    );

    typedef struct {
        logic        full;   // 0: bubble, only the write-back enables are checked
        logic        wwreg;
        logic        wm2reg;
        logic [31:0] wmo;
        logic [31:0] walu;
        logic [4:0]  wrn;
    } wexp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          ncyc;
    } bexp_t;

    typedef struct {
        logic        mwreg, mm2reg, mwmem, stray;
        logic [31:0] malu, mb, rdata;
        logic [4:0]  mrn;
        int          ack_cyc;
        wexp_t       w;
        int          stalls;
        int          reqcyc;
    } vec_t;

    wexp_t w_q[$];
    bexp_t b_q[$];
    int    checks = 0;
    int    failures = 0;

    logic        m_valid = 1'b0;
    logic        retire_pending = 1'b0;
    int          bus_cyc = 0;
    int          err_count = 0;
    wexp_t       mon_e;
    bexp_t       mon_b;

    int          req_cyc = 0;
    int          ack_cyc = 0;
    logic [31:0] cur_rdata = '0;
    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Bus responder: acks on REQ cycle ack_cyc (0 = never). Outside REQ it
    // drives stray_ack, which the DUT must ignore.
    always @(posedge clock) begin
        #1;
        if (mem_req) begin
            req_cyc++;
            resp_ack = (ack_cyc != 0) && (req_cyc >= ack_cyc);
        end else begin
            req_cyc = 0;
            resp_ack = 1'b0;
        end
    end
    assign mem_ack   = mem_req ? resp_ack : stray_ack;
    assign mem_rdata = mem_req ? cur_rdata : 32'hBAD0_BAD0;

    // Monitor: an instruction retires on an edge where it was in M with no
    // stall, and its MEM/WB result is compared one cycle later. Bus fields are
    // checked on every REQ cycle, and the REQ length is checked when mem_req
    // drops.
    always @(negedge clock) begin
        if (retire_pending) begin
            if (w_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL w_unexpected actual=retire required=none");
            end else begin
                mon_e = w_q.pop_front();
                chk("w_wwreg",  32'(wwreg),  32'(mon_e.wwreg));
                chk("w_wm2reg", 32'(wm2reg), 32'(mon_e.wm2reg));
                if (mon_e.full) begin
                    chk("w_wmo",  wmo,  mon_e.wmo);
                    chk("w_walu", walu, mon_e.walu);
                    chk("w_wrn",  32'(wrn), 32'(mon_e.wrn));
                end
            end
        end
        retire_pending = m_valid && !mstall && resetn;

        if (mem_req) begin
            if (b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL bus_unexpected actual=mem_req required=idle");
            end else begin
                chk("bus_addr",  mem_addr,  b_q[0].addr);
                chk("bus_wdata", mem_wdata, b_q[0].wdata);
                chk("bus_we",    32'(mem_we), 32'(b_q[0].we));
            end
            bus_cyc++;
        end else if (bus_cyc > 0) begin
            if (b_q.size() != 0) begin
                mon_b = b_q.pop_front();
                chk("bus_req_cycles", 32'(bus_cyc), 32'(mon_b.ncyc));
            end
            bus_cyc = 0;
        end

        if (mem_err) err_count++;
    end

    function automatic vec_t mk(input logic wr, input logic ld, input logic st,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] rn,
                                input int ack, input logic [31:0] rd, input logic stray,
                                input logic full, input logic e_wr, input logic e_ld,
                                input logic [31:0] e_mo, input logic [31:0] e_alu,
                                input logic [4:0] e_rn, input int stalls, input int reqc);
        vec_t v;
        v.mwreg = wr; v.mm2reg = ld; v.mwmem = st; v.malu = a; v.mb = b; v.mrn = rn;
        v.ack_cyc = ack; v.rdata = rd; v.stray = stray;
        v.w.full = full; v.w.wwreg = e_wr; v.w.wm2reg = e_ld; v.w.wmo = e_mo;
        v.w.walu = e_alu; v.w.wrn = e_rn;
        v.stalls = stalls; v.reqcyc = reqc;
        return v;
    endfunction

    task automatic clear_inputs();
        mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
        malu = '0; mb = '0; mrn = '0;
    endtask

    task automatic issue(input vec_t v);
        bexp_t b;
        int    stalls;
        bit    done;
        mwreg = v.mwreg; mm2reg = v.mm2reg; mwmem = v.mwmem;
        malu = v.malu; mb = v.mb; mrn = v.mrn;
        ack_cyc = v.ack_cyc; cur_rdata = v.rdata; stray_ack = v.stray;
        m_valid = 1'b1;
        w_q.push_back(v.w);
        if (v.mm2reg | v.mwmem) begin
            b.addr = v.malu; b.wdata = v.mb; b.we = v.mwmem; b.ncyc = v.reqcyc;
            b_q.push_back(b);
        end
        stalls = 0;
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clock);
            if (mstall) stalls++;
            else done = 1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL stall_bound actual=stalled required=release_within_300");
        end
        chk("stall_cycles", 32'(stalls), 32'(v.stalls));
        @(posedge clock);
        #1;
        m_valid = 1'b0;
        stray_ack = 1'b0;
        clear_inputs();
    endtask

    // Start a load that never gets an ack and reset it in REQ cycle n.
    task automatic abandon(input int n);
        bexp_t b;
        int    stalls;
        mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0;
        malu = 32'h0000_0300; mb = '0; mrn = 5'd6;
        ack_cyc = 0; cur_rdata = 32'h1357_9BDF;
        b.addr = 32'h0000_0300; b.wdata = '0; b.we = 1'b0; b.ncyc = n;
        b_q.push_back(b);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (mstall) stalls++;
            if (mem_err) begin
                checks++; failures++;
                $display("FAIL abandon_mem_err actual=1 required=0");
            end
            @(posedge clock);
            #1;
        end
        chk("abandon_stalls", 32'(stalls), 32'(n));
        resetn = 1'b0;
        clear_inputs();
        @(posedge clock);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we",  32'(mem_we),  32'd0);
        chk("rst_wwreg",   32'(wwreg),   32'd0);
        chk("rst_wm2reg",  32'(wm2reg),  32'd0);
        chk("rst_wmo",     wmo,          32'd0);
        chk("rst_walu",    walu,         32'd0);
        chk("rst_wrn",     32'(wrn),     32'd0);
        resetn = 1'b1;
        stray_ack = 1'b1;
        @(posedge clock);
        #1;
        stray_ack = 1'b0;
        chk("late_ack_mem_req", 32'(mem_req), 32'd0);
        chk("late_ack_wwreg",   32'(wwreg),   32'd0);
        chk("late_ack_mstall",  32'(mstall),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        clear_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_mstall",    32'(mstall),  32'd0);
        chk("reset_mem_req",   32'(mem_req), 32'd0);
        chk("reset_mem_we",    32'(mem_we),  32'd0);
        chk("reset_mem_addr",  mem_addr,     32'd0);
        chk("reset_mem_wdata", mem_wdata,    32'd0);
        chk("reset_wwreg",     32'(wwreg),   32'd0);
        chk("reset_wm2reg",    32'(wm2reg),  32'd0);
        chk("reset_wmo",       wmo,          32'd0);
        chk("reset_walu",      walu,         32'd0);
        chk("reset_wrn",       32'(wrn),     32'd0);
        chk("reset_mem_err",   32'(mem_err), 32'd0);
        resetn = 1'b1;

        //          wr ld st malu          mb            rn  ack rdata         stray full ewr eld e_wmo         e_walu        e_rn st rq
        vecs.push_back(mk(1, 0, 0, 32'h0000_1234, 32'h0,        5,  0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0000_1234, 5,  0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0000_0100, 32'h0,        7,  1, 32'hDEAD_BEEF, 0, 1, 1, 1, 32'hDEAD_BEEF, 32'h0000_0100, 7,  1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0040, 32'hA5A5_A5A5, 0, 4, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0000_0040, 0,  4, 4));
        vecs.push_back(mk(1, 1, 0, 32'h0000_0080, 32'h0,        9,  2, 32'h0BAD_F00D, 1, 1, 1, 1, 32'h0BAD_F00D, 32'h0000_0080, 9,  2, 2));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0044, 32'h1122_3344, 3, 1, 32'hCAFE_BABE, 0, 1, 1, 0, 32'h0,        32'h0000_0044, 3,  1, 1));
        vecs.push_back(mk(0, 0, 0, 32'hFFFF_FFFF, 32'h0,        31, 0, 32'h0,        1, 1, 0, 0, 32'h0,        32'hFFFF_FFFF, 31, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0000_0000, 32'h0,        1,  0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0000_0000, 1,  0, 0));
`ifdef PIPE_MEM_TIMEOUT_EN
        vecs.push_back(mk(1, 1, 0, 32'h0000_0200, 32'h0,        4,  0, 32'h7777_7777, 0, 0, 0, 0, 32'h0,        32'h0,         0,  4, 4));
`endif
        vecs.push_back(mk(1, 0, 0, 32'h0000_5678, 32'h0,        12, 0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0000_5678, 12, 0, 0));

        foreach (vecs[i]) issue(vecs[i]);

        abandon(2);
`ifndef PIPE_MEM_TIMEOUT_EN
        abandon(121);
`endif

        issue(mk(1, 1, 0, 32'h0000_0010, 32'h0, 2, 1, 32'h0246_8ACE, 0, 1, 1, 1, 32'h0246_8ACE, 32'h0000_0010, 2, 1, 1));

        repeat (3) @(posedge clock);
        #1;
`ifdef PIPE_MEM_TIMEOUT_EN
        chk("mem_err_pulses", 32'(err_count), 32'd1);
`else
        chk("mem_err_pulses", 32'(err_count), 32'd0);
`endif
        chk("w_queue_drained", 32'(w_q.size()), 32'd0);
        chk("b_queue_drained", 32'(b_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
